// File: rtl/l8_pkg.sv
// l8_pkg: types and constants shared by the layer-8 buffer controller and the layer-8 bank.
package l8_pkg;

    localparam int L8_LANE_WIDTH = 16;
    localparam int L8_LANES      = 16;
    localparam int L8_ADDR_WIDTH = 10;
    localparam int L8_DEPTH      = 1024;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } l8_state_e;

endpackage

// File: rtl/l8_buf_ctrl_skid.sv
// l8_skid_buf: two-entry valid/ready buffer; the head entry is the registered output stage.
module l8_skid_buf #(
    parameter int W = 257
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_payload,
    output logic [1:0]   count
);
    logic         head_v, spare_v;
    logic [W-1:0] head, spare;
    logic         pop;

    assign pop         = head_v && out_ready;
    assign out_valid   = head_v;
    assign out_payload = head;
    assign count       = {head_v && spare_v, head_v ^ spare_v};

    // Head refills from the spare slot first so ordering is preserved; pushes never
    // arrive into a full buffer because the caller only issues reads against free credit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_v  <= 1'b0;
            spare_v <= 1'b0;
            head    <= '0;
            spare   <= '0;
        end else if (!head_v || pop) begin
            if (spare_v) begin
                head    <= spare;
                head_v  <= 1'b1;
                spare_v <= push;
                if (push) begin
                    spare <= push_data;
                end
            end else begin
                head_v <= push;
                if (push) begin
                    head <= push_data;
                end
            end
        end else if (push) begin
            spare_v <= 1'b1;
            spare   <= push_data;
        end
    end

endmodule

// File: rtl/l8_buf_ctrl.sv
// l8_buf_ctrl: writes one frame of vectors into the layer-8 bank, then reads it back in order to layer 9.
// Build option: define L8_RELU_EN to clamp negative lanes to zero on the write path.
module l8_buf_ctrl
    import l8_pkg::*;
#(
    parameter int M          = L8_LANES,
    parameter int DATA_WIDTH = L8_LANE_WIDTH,
    parameter int ADDR_WIDTH = L8_ADDR_WIDTH,
    parameter int DEPTH      = L8_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [M*DATA_WIDTH-1:0] in_data,
    output logic                    mem_wr,
    output logic [ADDR_WIDTH-1:0]   mem_addr1,
    output logic [M*DATA_WIDTH-1:0] mem_q,
    output logic [ADDR_WIDTH-1:0]   mem_addr2,
    input  logic [M*DATA_WIDTH-1:0] mem_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [M*DATA_WIDTH-1:0] out_data,
    output logic                    out_last,
    output logic                    frame_done
);
    localparam int VW = M * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    if (DEPTH < 2 || DEPTH > (2 ** ADDR_WIDTH)) begin : g_depth_check
        $error("l8_buf_ctrl: DEPTH out of range for ADDR_WIDTH");
    end

    l8_state_e             state, state_next;
    logic [ADDR_WIDTH-1:0] wcnt, rcnt;
    logic                  in_hs, out_hs, rd_issue;
    logic                  rd_pend, rd_pend_last;
    logic [1:0]            skid_count;
    logic [VW-1:0]         wr_data;
    logic [VW:0]           skid_payload;

    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign mem_addr2 = rcnt;
    assign out_data  = skid_payload[VW-1:0];
    assign out_last  = skid_payload[VW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // A read may issue only if the skid buffer still has room once this cycle's
    // pop and the read already in flight in the bank are accounted for.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        rd_issue   = 1'b0;
        unique case (state)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid && wcnt == LAST_ADDR) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                rd_issue = ({1'b0, skid_count} + {2'b00, rd_pend}) < (3'd2 + {2'b00, out_hs});
                if (rd_issue && rcnt == LAST_ADDR) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (out_hs && out_last) begin
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        wr_data = in_data;
`ifdef L8_RELU_EN
        for (int i = 0; i < M; i++) begin
            if (in_data[i*DATA_WIDTH + DATA_WIDTH - 1]) begin
                wr_data[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
`endif
    end

    // Both counters return to zero right after their final use, so they are
    // already clear when the frame ends and never step past DEPTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= '0;
            rcnt <= '0;
        end else begin
            if (in_hs) begin
                wcnt <= (wcnt == LAST_ADDR) ? '0 : wcnt + 1'b1;
            end
            if (rd_issue) begin
                rcnt <= (rcnt == LAST_ADDR) ? '0 : rcnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wr    <= 1'b0;
            mem_addr1 <= '0;
            mem_q     <= '0;
        end else begin
            mem_wr <= in_hs;
            if (in_hs) begin
                mem_addr1 <= wcnt;
                mem_q     <= wr_data;
            end
        end
    end

    // Tracks the one-cycle bank read so its data and last flag meet the skid buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend      <= 1'b0;
            rd_pend_last <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            rd_pend      <= rd_issue;
            rd_pend_last <= rd_issue && (rcnt == LAST_ADDR);
            frame_done   <= out_hs && out_last;
        end
    end

    l8_skid_buf #(
        .W(VW + 1)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (rd_pend),
        .push_data  ({rd_pend_last, mem_out}),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_payload(skid_payload),
        .count      (skid_count)
    );

endmodule

// File: doc/l8_buf_ctrl.md
# l8_buf_ctrl

Buffer controller for the layer-8 activation store. Accepts a valid/ready stream of M-lane, 16-bit pixel vectors from the layer-8 PE array and drives the write port (addr1/wr/q) of the 16-lane layer-8 memory bank. After one full frame of DEPTH vectors is written, it sweeps the bank's read port (addr2/out) in order and presents the vectors as a valid/ready stream to layer 9.

## Interface
- M, 16: lanes per vector; matches the bank's lane count
- DATA_WIDTH, 16: bits per lane
- ADDR_WIDTH, 10: bank address width
- DEPTH, 1024: vectors per frame; constraint 2 ≤ DEPTH ≤ 2**ADDR_WIDTH

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream vector valid
- in_ready  out  1  controller can accept a vector
- in_data  in  M*DATA_WIDTH  upstream vector; lane i = bits [16*(i+1)-1:16*i]
- mem_wr  out  1  bank write enable
- mem_addr1  out  ADDR_WIDTH  bank write address
- mem_q  out  M*DATA_WIDTH  bank write data
- mem_addr2  out  ADDR_WIDTH  bank read address
- mem_out  in  M*DATA_WIDTH  bank read data, valid 1 cycle after mem_addr2 (synchronous read)
- out_valid  out  1  downstream vector valid
- out_ready  in  1  downstream accepts
- out_data  out  M*DATA_WIDTH  downstream vector
- out_last  out  1  marks vector DEPTH-1, qualified by out_valid
- frame_done  out  1  one-cycle pulse after the last output handshake

## Operation
- The FSM has three states: FILL, DRAIN and FLUSH. Reset state is FILL.
- **FILL:**
  - in_ready is 1.
  - Each in_valid&&in_ready handshake registers in_data and the write counter wcnt.
  - On the next cycle: mem_wr=1, mem_addr1=wcnt, mem_q=the registered data.
  - wcnt increments per handshake.
  - When the handshake with wcnt==DEPTH-1 occurs, in_ready drops to 0 from the following cycle and the FSM moves to DRAIN.
- **DRAIN:**
  - The read counter rcnt drives mem_addr2.
  - A read is issued (rcnt increments) only when the skid buffer has a free slot, counting reads already in flight.
  - Returning mem_out enters the skid buffer.
  - After the read with rcnt==DEPTH-1 is issued, the FSM moves to FLUSH.
- **FLUSH:**
  - No new reads are issued.
  - On the out handshake carrying out_last: frame_done=1 for one cycle, the FSM returns to FILL, and wcnt and rcnt clear to 0.
- in_ready is 0 throughout DRAIN and FLUSH. Write and read phases never overlap, so there are no address collisions.
- Ordering: output vector k equals input vector k; nothing is dropped or duplicated under any out_ready pattern.
- Reset mid-operation aborts the frame:
  - The FSM returns to FILL and all counters clear.
  - Bank contents are not cleared.
  - The next frame overwrites from address 0.
- Reset values:
  - in_ready=1
  - mem_wr=0, mem_addr1=0, mem_q=0, mem_addr2=0
  - out_valid=0, out_data=0, out_last=0, frame_done=0

## Timing
- Write latency: handshake at cycle t gives mem_wr at t+1.
- Read latency: the first drain read is issued in the first DRAIN cycle. With out_ready held at 1, out_valid rises 2 cycles later (1 cycle bank read + 1 cycle output register).
- Throughput: 1 vector/cycle in each direction. A frame takes DEPTH fill cycles + DEPTH+2 drain cycles at full rate.
- Backpressure:
  - out_data and out_last hold stable while out_valid&&!out_ready.
  - A read issued before out_ready fell is captured in the skid buffer, never lost.
- Address wrap: counters never exceed DEPTH-1. With DEPTH==2**ADDR_WIDTH, the last address is all-ones and the counter does not wrap mid-frame.

## Configuration
- L8_RELU_EN:
  - Defined: each lane of mem_q is max(lane, 0), treating the lane as signed 16-bit. 0x8000 and all negative values are written as 0x0000.
  - Undefined: mem_q is in_data bit-exact.
  - Latency is identical either way.

## Structure
- Shared package l8_pkg holds:
  - the FSM state enum (FILL, DRAIN, FLUSH)
  - the lane width constant 16
  - the default DEPTH/ADDR_WIDTH constants shared with the layer-8 bank
- One sub-module, l8_skid_buf: a 2-entry valid/ready buffer, M*DATA_WIDTH+1 bits wide (data plus last). It owns out_valid, out_data and out_last.

## Test plan
- Reset, then DEPTH=4, four back-to-back inputs 0x0001..0x0004 (all lanes), out_ready=1 -> mem_wr at addresses 0..3 on consecutive cycles; outputs 1,2,3,4 with out_last on 4; frame_done one cycle after.
- DEPTH=4, out_ready toggling 1,0,0,1,0,1 during drain -> outputs still 1,2,3,4 in order; out_data stable while stalled; no extra or missing beats.
- in_valid presented during DRAIN -> in_ready=0, no mem_wr. The second frame starts from address 0 after frame_done.
- Assert rst_n low mid-DRAIN after 2 outputs -> all outputs reset immediately. The next frame of 5,6,7,8 outputs 5,6,7,8.
- L8_RELU_EN defined, lanes 0xFFFF, 0x8000, 0x7FFF, 0x0000 -> mem_q lanes 0x0000, 0x0000, 0x7FFF, 0x0000. Undefined: unchanged.
- DEPTH=1024, ADDR_WIDTH=10, continuous traffic -> mem_addr1 and mem_addr2 reach 0x3FF exactly once per frame; out_last only at vector 1023.
